// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encoding,
// default geometry and helpers that derive the chunk count and the width
// of the chunk counter from the operand width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width, never narrower than one bit so a single-chunk build
    // still has a legal counter.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/ripple_chunk.sv
// CHUNK-bit ripple-carry adder slice. Besides the carry out it exposes the
// carry into its top bit so the caller can compute signed overflow when this
// slice handles the most significant chunk.
module ripple_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    // Full-adder chain, bit 0 first, carries rippling upward.
    always_comb begin
        c     = '0;
        sum   = '0;
        c[0]  = ci;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co    = c[CHUNK];
        c_msb = c[CHUNK - 1];
    end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor that consumes its operands CHUNK bits per
// clock, least significant chunk first. The operand registers shift right
// each cycle so the active chunk always sits at bit 0, and the partial result
// is shifted in from the top so it is fully aligned after the last chunk.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = calc_cnt_w(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [CHUNK-1:0]       chunk_sum;
    logic                   chunk_co;
    logic                   chunk_msb;
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic [WIDTH-1:0]       next_res;

    // One adder slice shared by every RUN cycle.
    ripple_chunk #(
        .CHUNK (CHUNK)
    ) u_ripple (
        .x     (a_reg[CHUNK-1:0]),
        .y     (b_reg[CHUNK-1:0]),
        .ci    (carry),
        .sum   (chunk_sum),
        .co    (chunk_co),
        .c_msb (chunk_msb)
    );

    // New chunk enters at the top; the oldest bits slide toward bit 0.
    assign res_cat  = {chunk_sum, res_reg};
    assign next_res = res_cat[WIDTH+CHUNK-1:CHUNK];

    // Control FSM plus datapath registers; results only change on the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> CHUNK;
                    b_reg   <= b_reg >> CHUNK;
                    res_reg <= next_res;
                    carry   <= chunk_co;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CHUNK) begin
                        s        <= next_res;
                        c_out    <= chunk_co;
                        overflow <= chunk_msb ^ chunk_co;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder (WIDTH=16, CHUNK=4).
// Stimulus pushes the hand-computed result of every accepted operation into
// a queue; an independent monitor pops and compares on each done pulse.
module tb_chunked_serial_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c_out;
        logic             ovf;
        string            name;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             overflow;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    chunked_serial_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_done: got done=1 with s=0x%0h, expected no done", s);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_s"},     32'(s),        32'(e.s));
                checkOutput({e.name, "_c_out"}, 32'(c_out),    32'(e.c_out));
                checkOutput({e.name, "_ovf"},   32'(overflow), 32'(e.ovf));
            end
        end
    end

    // Issue one operation, wait (bounded) for done, and check handshake timing.
    task automatic applyStimulus(input logic sub_i, input logic [WIDTH-1:0] a_i,
                                 input logic [WIDTH-1:0] b_i, input logic cin_i,
                                 input logic [WIDTH-1:0] exp_s, input logic exp_c,
                                 input logic exp_o, input string name);
        exp_t e;
        int   lat;
        int   busy_cycles;
        e.s = exp_s; e.c_out = exp_c; e.ovf = exp_o; e.name = name;
        start = 1'b1; sub = sub_i; a = a_i; b = b_i; c_in = cin_i;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd4);
        checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'd4);
        checkOutput({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   n;
        logic saw_done;
        exp_t e;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
        #12;
        checkOutput("reset_s",     32'(s),        32'd0);
        checkOutput("reset_c_out", 32'(c_out),    32'd0);
        checkOutput("reset_ovf",   32'(overflow), 32'd0);
        checkOutput("reset_busy",  32'(busy),     32'd0);
        checkOutput("reset_done",  32'(done),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic add/sub vectors");
        applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_5555");
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "add_cin");
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");

        $display("[TB] start held during RUN");
        e.s = 16'h3333; e.c_out = 1'b0; e.ovf = 1'b0; e.name = "held_start";
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; c_in = 1'b1;
        @(posedge clk); #1;
        a = 16'hA5A5; b = 16'h5A5A;
        @(posedge clk); #1;
        checkOutput("held_s_stable_in_run", 32'(s), 32'hFFFE);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("held_done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("held_idle_after", 32'(busy), 32'd0);

        $display("[TB] back-to-back start in DONE");
        e.s = 16'h1000; e.c_out = 1'b0; e.ovf = 1'b0; e.name = "b2b_first";
        start = 1'b1; sub = 1'b0; a = 16'h00FF; b = 16'h0F01; c_in = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("b2b_first_latency", 32'(n), 32'd4);
        e.s = 16'h8000; e.c_out = 1'b0; e.ovf = 1'b1; e.name = "b2b_second";
        start = 1'b1; sub = 1'b0; a = 16'h7FFF; b = 16'h0001; c_in = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("b2b_busy_after_accept", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("b2b_done_spacing", 32'(n), 32'd5);
        @(posedge clk); #1;

        $display("[TB] reset during RUN");
        start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h1111; c_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_s",     32'(s),        32'd0);
        checkOutput("abort_c_out", 32'(c_out),    32'd0);
        checkOutput("abort_ovf",   32'(overflow), 32'd0);
        checkOutput("abort_busy",  32'(busy),     32'd0);
        checkOutput("abort_done",  32'(done),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(saw_done), 32'd0);
        applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_abort");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
